mux_pipe: RTL and testbench



---
 rtl/mux_pipe.sv | 103 ++++++++++
 tb/tb_mux_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_pipe.sv
// Registered N:1 mux with per-channel valid/ready and one output stage.
// Define MUX_PIPE_RR_EN to arbitrate round-robin instead of using sel.
module mux_pipe #(
  parameter  int WIDTH  = 5,
  parameter  int NUM_IN = 8,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_chan,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  logic             can_load;
  logic             gnt_ok;
  logic             xfer;
  logic [SEL_W-1:0] gnt;
  logic [WIDTH-1:0] gnt_data;

  assign out_valid = (state == FULL);
  assign can_load  = !out_valid || out_ready;

`ifdef MUX_PIPE_RR_EN
  logic [SEL_W-1:0] rr_ptr;
  logic             unused_sel;
  int               best;
  int               dist;

  assign unused_sel = ^sel;

  // Pick the valid channel closest to rr_ptr, walking upward with wrap.
  always_comb begin
    gnt    = '0;
    gnt_ok = 1'b0;
    best   = NUM_IN;
    dist   = 0;
    for (int i = 0; i < NUM_IN; i++) begin
      dist = i - int'(rr_ptr);
      if (dist < 0)
        dist = dist + NUM_IN;
      if (in_valid[i] && dist < best) begin
        best   = dist;
        gnt    = SEL_W'(i);
        gnt_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rr_ptr <= '0;
    else if (xfer)
      rr_ptr <= (int'(gnt) == NUM_IN - 1) ? '0 : gnt + 1'b1;
  end
`else
  assign gnt    = sel;
  assign gnt_ok = int'(sel) < NUM_IN;
`endif

  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (SEL_W'(i) == gnt) begin
        gnt_data    = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = gnt_ok && can_load;
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= EMPTY;
      out_data <= '0;
      out_chan <= '0;
    end else begin
      if (xfer) begin
        out_data <= gnt_data;
        out_chan <= gnt;
      end
      case (state)
        EMPTY: if (xfer) state <= FULL;
        FULL:  if (!xfer && out_ready) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_pipe.sv
// Bench for mux_pipe: directed table, corner sequences, random vs model.
// Covers fixed-select mode, or round-robin when MUX_PIPE_RR_EN is defined.
module tb_mux_pipe;
  localparam int W  = 5;
  localparam int N  = 8;
  localparam int SW = 3;
  localparam int DW = N * W;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [SW-1:0] sel;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_chan;
  logic          out_valid;
  logic          out_ready;

  logic [29:0]   in_data6;
  logic [5:0]    in_valid6;
  logic [5:0]    in_ready6;
  logic [2:0]    sel6;
  logic [W-1:0]  out_data6;
  logic [2:0]    out_chan6;
  logic          out_valid6;
  logic          out_ready6;

  mux_pipe #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_pipe #(.WIDTH(W), .NUM_IN(6)) dut6 (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
    .sel(sel6), .out_data(out_data6), .out_chan(out_chan6),
    .out_valid(out_valid6), .out_ready(out_ready6)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          m_valid;
  bit [W-1:0]  m_data;
  bit [SW-1:0] m_chan;
  int          m_ptr;

  typedef struct {
    logic [SW-1:0] sel;
    logic [N-1:0]  vld;
    bit            rdy;
    logic [N-1:0]  er;
    bit            ev;
    logic [W-1:0]  ed;
    logic [SW-1:0] ec;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int grant();
`ifdef MUX_PIPE_RR_EN
    for (int k = 0; k < N; k++) begin
      int idx = (m_ptr + k) % N;
      if (in_valid[idx]) return idx;
    end
    return -1;
`else
    return (int'(sel) < N) ? int'(sel) : -1;
`endif
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_data  = '0;
    m_chan  = '0;
    m_ptr   = 0;
  endtask

  // One clock: check in_ready, advance model, check registered outputs.
  task automatic cycle();
    int           g;
    bit           can;
    bit           take;
    logic [N-1:0] er;
    logic [W-1:0] nd;
    #1;
    g    = grant();
    can  = !m_valid || out_ready;
    er   = '0;
    nd   = '0;
    if (g >= 0 && can) er[g] = 1'b1;
    take = (g >= 0) && can && in_valid[g];
    if (take) nd = in_data[g*W +: W];
    chk("in_ready", in_ready, er);
    @(posedge clk);
    #1;
    if (take) begin
      m_valid = 1;
      m_data  = nd;
      m_chan  = SW'(g);
      m_ptr   = (g + 1) % N;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_chan", out_chan, m_chan);
  endtask

  initial begin
    int ord[6] = '{0, 2, 7, 0, 2, 7};
    for (int i = 0; i < N; i++)
      in_data[i*W +: W] = W'((i * 7 + 5) % 32);
    in_valid   = '0;
    sel        = '0;
    out_ready  = 1'b0;
    in_data6   = 30'h1234_5678;
    in_valid6  = '0;
    sel6       = '0;
    out_ready6 = 1'b1;
    model_reset();

    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_chan", out_chan, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

`ifndef MUX_PIPE_RR_EN
    tv[0] = '{3'd3, 8'h08, 1'b1, 8'h08, 1'b1, 5'h1A, 3'd3};
    tv[1] = '{3'd5, 8'h20, 1'b0, 8'h00, 1'b1, 5'h1A, 3'd3};
    tv[2] = '{3'd5, 8'h20, 1'b1, 8'h20, 1'b1, 5'h08, 3'd5};
    tv[3] = '{3'd2, 8'h00, 1'b1, 8'h04, 1'b0, 5'h08, 3'd5};
    tv[4] = '{3'd1, 8'hFD, 1'b0, 8'h02, 1'b0, 5'h08, 3'd5};
    tv[5] = '{3'd6, 8'h40, 1'b0, 8'h40, 1'b1, 5'h0F, 3'd6};
    tv[6] = '{3'd0, 8'hFF, 1'b0, 8'h00, 1'b1, 5'h0F, 3'd6};
    foreach (tv[i]) begin
      sel       = tv[i].sel;
      in_valid  = tv[i].vld;
      out_ready = tv[i].rdy;
      #1;
      chk("tv_ready", in_ready, tv[i].er);
      @(posedge clk);
      #1;
      chk("tv_valid", out_valid, tv[i].ev);
      chk("tv_data", out_data, tv[i].ed);
      chk("tv_chan", out_chan, tv[i].ec);
    end
    m_valid = tv[6].ev;
    m_data  = tv[6].ed;
    m_chan  = tv[6].ec;

    sel       = 3'd5;
    in_valid  = 8'h20;
    out_ready = 1'b0;
    repeat (4) cycle();
    chk("bp_hold", out_data, 5'h0F);
    out_ready = 1'b1;
    cycle();
    chk("bp_chan", out_chan, 5);
    chk("bp_valid", out_valid, 1);

    in_valid = '1;
    for (int i = 0; i < N; i++) begin
      sel = SW'(i);
      cycle();
      chk("stream_chan", out_chan, i);
    end

    sel6      = 3'd7;
    in_valid6 = 6'h3F;
    repeat (3) begin
      #1;
      chk("n6_ready", in_ready6, 0);
      @(posedge clk);
      #1;
      chk("n6_valid", out_valid6, 0);
    end
    sel6 = 3'd4;
    #1;
    chk("n6_ready4", in_ready6, 6'h10);
    @(posedge clk);
    #1;
    chk("n6_valid4", out_valid6, 1);
    chk("n6_chan4", out_chan6, 4);
    chk("n6_data4", out_data6, in_data6[20 +: 5]);
`endif

    // Reset while the output register holds data.
    sel       = 3'd2;
    in_valid  = '1;
    out_ready = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_chan", out_chan, 0);
    model_reset();
    sel       = 3'd0;
    in_valid  = 8'h85;
    out_ready = 1'b1;
    #2;
    reset_n = 1'b1;

`ifdef MUX_PIPE_RR_EN
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_order", out_chan, ord[i]);
    end
`else
    cycle();
    chk("first_edge", out_chan, ord[0]);
`endif

    repeat (400) begin
      in_data   = DW'({$urandom(), $urandom()});
      in_valid  = N'($urandom());
      sel       = SW'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
